// File: rtl/psk_modulator.sv
// psk_modulator: DDS carrier with BPSK / Gray-QPSK phase shifting, 2-stage sample path.
// Define MOD_OFFSET_BINARY_EN for offset-binary mod_out (zero code = MSB only).
module psk_modulator #(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 8,
  parameter int DIV     = 25,
  parameter int SPS     = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               en,
  input  logic               mod_sel,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [1:0]         sym_data,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic [DATA_W-1:0]  mod_out,
  output logic               mod_valid,
  output logic               sym_strobe,
  output logic               underrun
);
  localparam int  DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int  SCW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int  LN  = 2 ** LUT_AW;
  localparam real AMP = (2.0 ** (DATA_W - 1)) - 1.0;
  localparam real PI  = 3.14159265358979323846;
`ifdef MOD_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] ZERO = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] ZERO = '0;
`endif

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  // LUT entries already carry the output code format
  logic [DATA_W-1:0] lut [LN];

  for (genvar k = 0; k < LN; k++) begin : g_lut
    localparam real X = AMP * $sin(2.0 * PI * k / LN);
    localparam int  V = (X < 0.0) ? -$rtoi(0.5 - X) : $rtoi(X + 0.5);
    assign lut[k] = DATA_W'(V) ^ ZERO;
  end

  state_t             state_q, state_d;
  logic [DCW-1:0]     div_q, div_d;
  logic [SCW-1:0]     cnt_q, cnt_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic               sel_q, sel_d;
  logic [1:0]         sym_q, sym_d;
  logic [1:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               rdy_q;
  logic [LUT_AW-1:0]  addr_q, addr_d;
  logic               s1_vld_q, s1_vld_d;
  logic               s1_zero_q, s1_zero_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               vld_q, vld_d;
  logic               strb_q, strb_d;
  logic               urun_q, urun_d;
  logic               tick, take, bound;
  logic [PHASE_W-1:0] ph;

  function automatic logic [PHASE_W-1:0] offset(
    input logic       sel,
    input logic [1:0] s
  );
    logic [PHASE_W-1:0] o;
    o = '0;
    if (sel) o[PHASE_W-1 -: 2] = {s[1], s[1] ^ s[0]};
    else     o[PHASE_W-1] = s[0];
    return o;
  endfunction

  always_comb begin
    tick  = en && (div_q == DCW'(DIV - 1));
    div_d = (tick || !en) ? '0 : div_q + 1'b1;
    take  = sym_valid && sym_ready;
    bound = (state_q == ARM) ||
            ((state_q == RUN) && (cnt_q == SCW'(SPS - 1)));

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ftw_d       = ftw_q;
    sel_d       = sel_q;
    sym_d       = sym_q;
    hold_d      = take ? sym_data : hold_q;
    hold_full_d = hold_full_q || take;
    ph          = '0;
    addr_d      = addr_q;
    s1_vld_d    = 1'b0;
    s1_zero_d   = 1'b1;
    strb_d      = 1'b0;
    urun_d      = 1'b0;

    if (!en) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = ARM;
    end else if (tick) begin
      s1_vld_d = 1'b1;
      if (bound && hold_full_q) begin
        // the loading tick already emits sample 0 of the new symbol
        ftw_d       = ftw;
        sel_d       = mod_sel;
        sym_d       = hold_q;
        hold_full_d = 1'b0;
        cnt_d       = '0;
        strb_d      = 1'b1;
        state_d     = RUN;
        s1_zero_d   = 1'b0;
        ph          = acc_q + offset(mod_sel, hold_q);
        acc_d       = acc_q + ftw;
      end else if (bound) begin
        urun_d  = (state_q == RUN);
        state_d = ARM;
      end else begin
        s1_zero_d = 1'b0;
        ph        = acc_q + offset(sel_q, sym_q);
        acc_d     = acc_q + ftw_q;
        cnt_d     = cnt_q + 1'b1;
      end
      addr_d = LUT_AW'(ph >> (PHASE_W - LUT_AW));
    end

    vld_d = en && s1_vld_q;
    if (!en)            out_d = ZERO;
    else if (!s1_vld_q) out_d = out_q;
    else if (s1_zero_q) out_d = ZERO;
    else                out_d = lut[addr_q];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ftw_q       <= '0;
      sel_q       <= 1'b0;
      sym_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rdy_q       <= 1'b0;
      addr_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_zero_q   <= 1'b1;
      out_q       <= ZERO;
      vld_q       <= 1'b0;
      strb_q      <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      sel_q       <= sel_d;
      sym_q       <= sym_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rdy_q       <= !hold_full_d;
      addr_q      <= addr_d;
      s1_vld_q    <= s1_vld_d;
      s1_zero_q   <= s1_zero_d;
      out_q       <= out_d;
      vld_q       <= vld_d;
      strb_q      <= strb_d;
      urun_q      <= urun_d;
    end
  end

  // rdy_q mirrors ~hold_full but stays low straight out of reset
  assign sym_ready  = en && rdy_q;
  assign mod_out    = out_q;
  assign mod_valid  = vld_q;
  assign sym_strobe = strb_q;
  assign underrun   = urun_q;
endmodule

// File: tb/tb_psk_modulator.sv
// tb_psk_modulator: randomized self-checking bench for psk_modulator.
// Reference samples come from the sine/phase rules evaluated with real arithmetic.
`timescale 1ns/1ps
module tb_psk_modulator;
  localparam real PI  = 3.14159265358979323846;
  localparam int  PER = 400;
`ifdef MOD_OFFSET_BINARY_EN
  localparam logic [7:0] FLIP = 8'h80;
`else
  localparam logic [7:0] FLIP = 8'h00;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en = 1'b0;
  logic        mod_sel = 1'b0;
  logic [15:0] ftw = 16'h1000;
  logic [1:0]  sym_data = 2'b00;
  logic        sym_valid = 1'b0;
  logic        sym_ready, mod_valid, sym_strobe, underrun;
  logic [7:0]  mod_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] outs[$];
  int out_cyc[$], strb_cyc[$], strb_idx[$], ur_cyc[$], xfer_cyc[$];
  int syms[$];

  psk_modulator #(
    .DATA_W(8), .PHASE_W(16), .LUT_AW(8), .DIV(25), .SPS(16)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en), .mod_sel(mod_sel), .ftw(ftw),
    .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .mod_out(mod_out), .mod_valid(mod_valid),
    .sym_strobe(sym_strobe), .underrun(underrun)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (sym_strobe) begin
        strb_cyc.push_back(cyc);
        strb_idx.push_back(outs.size());
      end
      if (mod_valid) begin
        outs.push_back(mod_out);
        out_cyc.push_back(cyc);
      end
      if (underrun) ur_cyc.push_back(cyc);
      if (sym_valid && sym_ready) xfer_cyc.push_back(cyc);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1);
  end

  function automatic logic [7:0] ref_code(input int ph);
    int  a;
    int  v;
    real x;
    a = (ph % 65536) / 256;
    x = 127.0 * $sin(2.0 * PI * a / 256.0);
    v = (x < 0.0) ? -$rtoi(0.5 - x) : $rtoi(x + 0.5);
    return 8'(v) ^ FLIP;
  endfunction

  function automatic int ref_off(input logic sel, input int d);
    if (!sel) return (d % 2) * 32768;
    case (d)
      1:       return 16384;
      3:       return 32768;
      2:       return 49152;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] tp_code(input int v);
    return 8'(v) ^ FLIP;
  endfunction

  task automatic clear_mon();
    outs.delete(); out_cyc.delete(); strb_cyc.delete();
    strb_idx.delete(); ur_cyc.delete(); xfer_cyc.delete();
    syms.delete();
  endtask

  task automatic restart(input logic sel, input logic [15:0] f);
    @(posedge CLK); #1;
    en = 1'b0;
    sym_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    mod_sel = sel;
    ftw = f;
    clear_mon();
    en = 1'b1;
  endtask

  task automatic send_sym(input logic [1:0] d);
    int n;
    n = 0;
    sym_data = d;
    sym_valid = 1'b1;
    @(negedge CLK);
    while (!sym_ready && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!sym_ready) begin
      errors++;
      $display("FAIL send_timeout ready=%b required=1", sym_ready);
    end
    @(posedge CLK); #1;
    sym_valid = 1'b0;
    syms.push_back(int'(d));
  endtask

  task automatic wait_underrun();
    for (int i = 0; i < 8000 && ur_cyc.size() == 0; i++)
      @(posedge CLK);
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if (ur_cyc.size() == 0) begin
      errors++;
      $display("FAIL underrun_timeout got=0 required=1");
    end
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({sym_ready, mod_valid, sym_strobe, underrun} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required=0000",
               {sym_ready, mod_valid, sym_strobe, underrun});
    end
    checks++;
    if (mod_out !== FLIP) begin
      errors++;
      $display("FAIL reset_out got=%h required=%h", mod_out, FLIP);
    end
    RST = 1'b0;
    restart(1'b0, 16'h1000);
    send_sym(2'd0);
    repeat (150) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if ({sym_ready, mod_valid, sym_strobe, underrun} !== 4'b0) begin
      errors++;
      $display("FAIL midrun_reset_flags got=%b required=0000",
               {sym_ready, mod_valid, sym_strobe, underrun});
    end
    checks++;
    if (mod_out !== FLIP) begin
      errors++;
      $display("FAIL midrun_reset_out got=%h required=%h", mod_out, FLIP);
    end
    en = 1'b0;
    #2;
    RST = 1'b0;
    clear_mon();
    bad = 0;
    repeat (1000) begin
      @(negedge CLK);
      if (mod_out !== FLIP || sym_ready || mod_valid || sym_strobe || underrun)
        bad++;
    end
    checks++;
    if (bad != 0 || outs.size() != 0) begin
      errors++;
      $display("FAIL idle_quiet got=%0d bad cycles required=0", bad);
    end
  endtask

  task automatic test_bpsk();
    int tp[8] = '{0, 127, 0, -127, 0, -127, 0, 127};
    restart(1'b0, 16'h1000);
    send_sym(2'd0);
    send_sym(2'd1);
    wait_underrun();
    checks++;
    if (strb_cyc.size() != 2 || strb_cyc[1] - strb_cyc[0] != PER) begin
      errors++;
      $display("FAIL bpsk_strobe_period got=%0d required=%0d",
               strb_cyc.size() == 2 ? strb_cyc[1] - strb_cyc[0] : -1, PER);
    end
    checks++;
    if (ur_cyc.size() != 1 || strb_cyc.size() < 2 ||
        ur_cyc[0] - strb_cyc[1] != PER) begin
      errors++;
      $display("FAIL bpsk_underrun got=%0d pulses required=1 at end", ur_cyc.size());
    end
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 16; k++) begin
        int idx;
        logic [7:0] got, exp;
        idx = (j < strb_idx.size()) ? strb_idx[j] + k : 1 << 20;
        got = (idx < outs.size()) ? outs[idx] : 8'hxx;
        exp = ref_code((j * 16 + k) * 4096 + ref_off(1'b0, syms[j]));
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL bpsk_sample s%0d k%0d got=%h required=%h", j, k, got, exp);
        end
        if (k % 4 == 0) begin
          checks++;
          if (got !== tp_code(tp[j * 4 + k / 4])) begin
            errors++;
            $display("FAIL bpsk_plan s%0d k%0d got=%h required=%h",
                     j, k, got, tp_code(tp[j * 4 + k / 4]));
          end
        end
      end
  endtask

  task automatic test_qpsk();
    int t0[4] = '{0, 127, 0, -127};
    int t4[4] = '{127, 0, -127, 0};
    int seq[4] = '{0, 1, 3, 2};
    restart(1'b1, 16'h1000);
    for (int j = 0; j < 4; j++) send_sym(2'(seq[j]));
    wait_underrun();
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 16; k++) begin
        int idx;
        logic [7:0] got, exp;
        idx = (j < strb_idx.size()) ? strb_idx[j] + k : 1 << 20;
        got = (idx < outs.size()) ? outs[idx] : 8'hxx;
        exp = ref_code((j * 16 + k) * 4096 + ref_off(1'b1, syms[j]));
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL qpsk_sample s%0d k%0d got=%h required=%h", j, k, got, exp);
        end
        if (k == 0 || k == 4) begin
          checks++;
          if (got !== tp_code(k == 0 ? t0[j] : t4[j])) begin
            errors++;
            $display("FAIL qpsk_plan s%0d k%0d got=%h required=%h",
                     j, k, got, tp_code(k == 0 ? t0[j] : t4[j]));
          end
        end
      end
  endtask

  task automatic test_underrun();
    int n0;
    restart(1'b0, 16'h1000);
    send_sym(2'd1);
    wait_underrun();
    checks++;
    if (strb_cyc.size() != 1 || ur_cyc.size() != 1 ||
        ur_cyc[0] - strb_cyc[0] != PER) begin
      errors++;
      $display("FAIL underrun_time got=%0d required=%0d",
               (ur_cyc.size() > 0 && strb_cyc.size() > 0) ?
               ur_cyc[0] - strb_cyc[0] : -1, PER);
    end
    n0 = outs.size();
    repeat (110) @(posedge CLK);
    #1;
    checks++;
    if (outs.size() - n0 < 4) begin
      errors++;
      $display("FAIL arm_samples got=%0d required>=4", outs.size() - n0);
    end
    for (int i = n0; i < outs.size(); i++) begin
      checks++;
      if (outs[i] !== FLIP || out_cyc[i] - out_cyc[i - 1] != 25) begin
        errors++;
        $display("FAIL arm_zero i%0d got=%h/%0d required=%h/25",
                 i, outs[i], out_cyc[i] - out_cyc[i - 1], FLIP);
      end
    end
    send_sym(2'd0);
    for (int i = 0; i < 200 && strb_cyc.size() < 2; i++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (strb_cyc.size() != 2 || strb_idx[1] >= outs.size() ||
        outs[strb_idx[1]] !== ref_code(16 * 4096)) begin
      errors++;
      $display("FAIL resume got=%0d strobes required=2 with sample %h",
               strb_cyc.size(), ref_code(16 * 4096));
    end
  endtask

  task automatic test_back_to_back();
    restart(1'b0, 16'h1000);
    sym_data = 2'd0;
    sym_valid = 1'b1;
    repeat (2100) @(posedge CLK);
    #1;
    sym_valid = 1'b0;
    checks++;
    if (xfer_cyc.size() < 5 || ur_cyc.size() != 0) begin
      errors++;
      $display("FAIL bp_count got=%0d xfers %0d underruns required>=5 and 0",
               xfer_cyc.size(), ur_cyc.size());
    end
    for (int i = 2; i < xfer_cyc.size(); i++) begin
      checks++;
      if (xfer_cyc[i] - xfer_cyc[i - 1] != PER) begin
        errors++;
        $display("FAIL bp_interval i%0d got=%0d required=%0d",
                 i, xfer_cyc[i] - xfer_cyc[i - 1], PER);
      end
    end
  endtask

  task automatic test_random();
    logic        sel;
    logic [15:0] f;
    int          ok;
    sel = 1'($urandom_range(0, 1));
    f = 16'($urandom_range(1, 65535));
    restart(sel, f);
    ok = 0;
    fork
      begin
        for (int j = 0; j < 5; j++) send_sym(2'($urandom_range(0, 3)));
      end
      begin
        for (int i = 0; i < 3000 && strb_cyc.size() < 2; i++) @(posedge CLK);
        if (strb_cyc.size() >= 2) begin
          ok = 1;
          repeat (100) @(posedge CLK);
          #1;
          ftw = f ^ 16'h5a5a;
          mod_sel = ~sel;
          repeat (200) @(posedge CLK);
          #1;
          ftw = f;
          mod_sel = sel;
        end
      end
    join
    wait_underrun();
    checks++;
    if (ok == 0) begin
      errors++;
      $display("FAIL rand_strobe_timeout got=%0d required=2", strb_cyc.size());
    end
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < 16; k++) begin
        int idx;
        logic [7:0] got, exp;
        idx = (j < strb_idx.size()) ? strb_idx[j] + k : 1 << 20;
        got = (idx < outs.size()) ? outs[idx] : 8'hxx;
        exp = ref_code(((j * 16 + k) * int'(f)) % 65536 + ref_off(sel, syms[j]));
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL rand_sample ftw=%h sel=%b s%0d k%0d got=%h required=%h",
                   f, sel, j, k, got, exp);
        end
      end
  endtask

  task automatic test_flush();
    int n0;
    int seen;
    restart(1'b0, 16'h1000);
    send_sym(2'd1);
    seen = 0;
    for (int i = 0; i < 2000 && seen == 0; i++) begin
      @(negedge CLK);
      if (sym_strobe) seen = 1;
    end
    #1;
    en = 1'b0;
    n0 = outs.size();
    repeat (50) @(posedge CLK);
    #1;
    checks++;
    if (seen == 0 || outs.size() != n0 || mod_out !== FLIP || sym_ready) begin
      errors++;
      $display("FAIL flush got=%0d extra samples out=%h ready=%b required=0 %h 0",
               outs.size() - n0, mod_out, sym_ready, FLIP);
    end
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qpsk();
    test_underrun();
    test_back_to_back();
    test_random();
    test_random();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
